sms_mem_arbiter: RTL
====================

Name: sms_mem_arbiter

Overview:
- Single-owner sequencer for the cartridge SDRAM byte port.
- Shares the port between three requesters:
  - HPS ROM download writer (ioctl stream).
  - Z80 ROM fetch path, including cart-size address masking.
  - Battery-backed save-RAM port.
- Issues one SDRAM operation at a time, waits for completion, routes read data back and acks the requester.
- Sits between hps_io/system and the sdram controller, on clk_sys.

Parameters:
- AW, 25, SDRAM byte address width.
- SAV_BASE, 25'h1F8_0000, SDRAM base address of the save-RAM window.
- SAV_AW, 15, save-RAM address width (32 KiB).
- TIMEOUT, 255, clk_sys cycles allowed in WAIT before abort.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dl_active  in  1  download in progress (ioctl_download).
- dl_wr  in  1  one-cycle write strobe.
- dl_addr  in  AW  download byte address.
- dl_data  in  8  download byte.
- dl_wait  out  1  high while a download write is pending; drives ioctl_wait.
- dl_ovf  out  1  sticky: dl_wr arrived while previous write still pending.
- cart_mask  in  8  bank mask applied to rom_addr[21:14].
- rom_req  in  1  level; held until rom_ack.
- rom_addr  in  22  ROM byte address.
- rom_data  out  8  read data; valid on rom_ack.
- rom_ack  out  1  one-cycle pulse.
- sav_req  in  1  level; held until sav_ack.
- sav_we  in  1  1 = write, 0 = read.
- sav_addr  in  SAV_AW  save-RAM byte address.
- sav_din  in  8  write data.
- sav_dout  out  8  read data; valid on sav_ack.
- sav_ack  out  1  one-cycle pulse.
- mem_addr  out  AW  SDRAM address.
- mem_din  out  8  SDRAM write data.
- mem_we  out  1  one-cycle write command.
- mem_rd  out  1  one-cycle read command.
- mem_dout  in  8  SDRAM read data.
- mem_ready  in  1  one-cycle completion pulse.
- err_timeout  out  1  sticky: an operation timed out.

Behaviour:
- Reset values: all outputs 0, FSM IDLE, dl_pend 0, rom cache invalid, sticky flags cleared.
- Download capture:
  - dl_wr sets dl_pend and latches dl_addr/dl_data.
  - dl_wait = dl_pend.
  - dl_wr while dl_pend=1 sets dl_ovf and overwrites the latch.
- FSM states IDLE, ISSUE, WAIT.
  - IDLE: grant in fixed priority dl_pend > rom_req > sav_req.
    - While dl_active=1, rom and sav are never granted; their requests stay held.
    - On grant, latch owner, address, data and direction, then go to ISSUE.
  - ISSUE: exactly one cycle of mem_we or mem_rd, then go to WAIT.
  - WAIT: on mem_ready, capture mem_dout (reads) and go to IDLE.
    - In that same cycle pulse the owner's ack; for a download, clear dl_pend.
- Addresses:
  - ROM: {3'b0, rom_addr[21:14] & cart_mask, rom_addr[13:0]}.
  - Save: SAV_BASE | sav_addr.
  - Download: dl_addr unmodified.
- ROM one-entry cache (tag = masked address):
  - In IDLE, a rom_req whose masked address equals a valid tag acks in the next cycle without any mem_rd.
  - A cache hit takes precedence over sav_req but not over dl_pend.
  - A completed ROM read loads the tag and data and sets valid.
  - Any download write completion or a rising edge of dl_active invalidates the cache.
  - Changing cart_mask does not invalidate; the tag compares the masked address.
- Latency, miss: grant at T, mem_rd at T+1, ack in the cycle mem_ready is seen. Minimum is T+2 with zero-latency memory.
- Timeout: an 8-bit counter runs in WAIT.
  - Reaching TIMEOUT returns the FSM to IDLE and sets err_timeout.
  - The owner is still acked, with data 8'hFF for reads.
  - A download write is dropped and dl_pend cleared.
- Simultaneous events:
  - mem_ready outside WAIT is ignored.
  - dl_wr in the same cycle as download completion: the new write stays pending; dl_ovf is not set.
  - rom_req deasserted before ack is illegal; the arbiter completes the operation anyway and pulses ack.
- Reset mid-operation aborts immediately: no ack, no further mem commands.

Optional Feature:
- Macro SMS_SAVE_PORT_EN.
- Defined: save-RAM port arbitrated as described.
- Undefined:
  - sav_* inputs ignored; sav_ack and sav_dout tied 0.
  - Grant logic reduces to dl_pend > rom_req.
  - SAV_BASE is unused.

Decomposition:
- Package sms_mem_pkg holds:
  - owner_t enum: OWN_DL, OWN_ROM, OWN_SAV.
  - state_t enum: IDLE, ISSUE, WAIT.
  - Constants: default SAV_BASE, default TIMEOUT.
  - Function rom_map(addr, mask) returning the masked SDRAM address.
- One natural sub-module: sms_rom_cache1 (tag/data/valid register with hit compare and invalidate).

Test Plan:
- Download: dl_active=1; dl_wr at 0x000000=0xA5 and 0x000001=0x5A, mem_ready 3 cycles after each command -> mem_we twice with matching addr/din, dl_wait high until each mem_ready, no dl_ovf.
- ROM miss, then hit:
  - Setup: cart_mask=0x07; rom_req at 0x3C123 (bank 0x0F), mem_dout=0x42.
  - First request -> mem_addr=0x01C123, rom_data=0x42.
  - Repeated request -> ack next cycle with 0x42 and no mem_rd.
- Priority: rom_req and sav_req high in the same cycle, cache miss -> ROM granted first, save serviced after; sav write to 0x0010 -> mem_addr=0x1F80010, mem_we.
- Invalidate: after a cached ROM read, one download write to any address -> next identical rom_req issues mem_rd.
- Timeout: rom_req with mem_ready never asserted -> after 255 WAIT cycles rom_ack with 0xFF, err_timeout=1, FSM accepts the next request.
- Async reset: reset_n low during WAIT -> all outputs 0 immediately, no ack; after release, a late mem_ready is ignored.

Source files
------------

// File: rtl/sms_mem_pkg.sv
// Shared types, defaults and the ROM address mapping for the cartridge SDRAM arbiter.
package sms_mem_pkg;

  typedef enum logic [1:0] {OWN_DL, OWN_ROM, OWN_SAV} owner_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [24:0] SAV_BASE_DEF = 25'h1F8_0000;
  localparam int          TIMEOUT_DEF  = 255;

  // Bank bits are masked by the cartridge size so mirrored banks share SDRAM.
  function automatic logic [24:0] rom_map(input logic [21:0] addr, input logic [7:0] mask);
    return {3'b000, addr[21:14] & mask, addr[13:0]};
  endfunction

endpackage

// File: rtl/sms_rom_cache1.sv
// One-entry ROM read cache: tag/data/valid with hit compare and invalidate.
module sms_rom_cache1 #(
  parameter int AW = 25
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [7:0]    hit_data,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          inval
);

  logic          valid;
  logic [AW-1:0] tag;
  logic [7:0]    data;

  // Invalidate wins over a coincident load so stale ROM never survives a download.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= 8'h00;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_addr;
      data  <= load_data;
    end
  end

  assign hit      = valid && (tag == lookup_addr);
  assign hit_data = data;

endmodule

// File: rtl/sms_mem_arbiter.sv
// Single-owner sequencer for the cartridge SDRAM byte port (download, ROM fetch, save RAM).
// Save-RAM port is built only when SMS_SAVE_PORT_EN is defined.
module sms_mem_arbiter
  import sms_mem_pkg::*;
#(
  parameter int            AW       = 25,
  parameter logic [AW-1:0] SAV_BASE = AW'(SAV_BASE_DEF),
  parameter int            SAV_AW   = 15,
  parameter int            TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [AW-1:0]     dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  output logic              dl_ovf,
  input  logic [7:0]        cart_mask,
  input  logic              rom_req,
  input  logic [21:0]       rom_addr,
  output logic [7:0]        rom_data,
  output logic              rom_ack,
  input  logic              sav_req,
  input  logic              sav_we,
  input  logic [SAV_AW-1:0] sav_addr,
  input  logic [7:0]        sav_din,
  output logic [7:0]        sav_dout,
  output logic              sav_ack,
  output logic [AW-1:0]     mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic              err_timeout
);

  state_t        state, state_nx;
  owner_t        owner;
  logic [AW-1:0] op_addr, dl_addr_q, rom_sdram, sav_sdram;
  logic [7:0]    op_data, dl_data_q, hit_data_q, cache_data, rd_val, wait_cnt;
  logic          op_we, dl_pend, dl_ovf_q, err_q, dl_active_q, hit_ack_q;
  logic          grant_dl, grant_rom, grant_sav, hit_take;
  logic          rom_ok, sav_ok, cache_hit;
  logic          timed_out, op_done, dl_done, rom_done, sav_done;

  assign rom_sdram = AW'(rom_map(rom_addr, cart_mask));
  // A registered hit ack is still in flight while the requester sees it, so hold off re-grant.
  assign rom_ok    = rom_req && !dl_active && !hit_ack_q;

`ifdef SMS_SAVE_PORT_EN
  assign sav_sdram = SAV_BASE | AW'(sav_addr);
  assign sav_ok    = sav_req && !dl_active;
`else
  logic unused_sav;
  assign sav_sdram  = '0;
  assign sav_ok     = 1'b0;
  assign unused_sav = ^{sav_req, sav_we, sav_addr, sav_din, SAV_BASE};
`endif

  assign timed_out = (state == WAIT) && !mem_ready && (wait_cnt == 8'(TIMEOUT - 1));
  assign op_done   = (state == WAIT) && (mem_ready || timed_out);
  assign rd_val    = mem_ready ? mem_dout : 8'hFF;
  assign dl_done   = op_done && (owner == OWN_DL);
  assign rom_done  = op_done && (owner == OWN_ROM);
  assign sav_done  = op_done && (owner == OWN_SAV);

  sms_rom_cache1 #(.AW(AW)) u_cache (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .lookup_addr (rom_sdram),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .load        (rom_done && mem_ready),
    .load_addr   (op_addr),
    .load_data   (mem_dout),
    .inval       (dl_done || (dl_active && !dl_active_q))
  );

  always_comb begin
    state_nx  = state;
    grant_dl  = 1'b0;
    grant_rom = 1'b0;
    grant_sav = 1'b0;
    hit_take  = 1'b0;
    case (state)
      IDLE: begin
        if (dl_pend) begin
          grant_dl = 1'b1;
          state_nx = ISSUE;
        end else if (rom_ok && cache_hit) begin
          hit_take = 1'b1;
        end else if (rom_ok) begin
          grant_rom = 1'b1;
          state_nx  = ISSUE;
        end else if (sav_ok) begin
          grant_sav = 1'b1;
          state_nx  = ISSUE;
        end
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (op_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= OWN_DL;
      op_addr     <= '0;
      op_data     <= 8'h00;
      op_we       <= 1'b0;
      wait_cnt    <= 8'h00;
      dl_pend     <= 1'b0;
      dl_addr_q   <= '0;
      dl_data_q   <= 8'h00;
      dl_ovf_q    <= 1'b0;
      err_q       <= 1'b0;
      dl_active_q <= 1'b0;
      hit_ack_q   <= 1'b0;
      hit_data_q  <= 8'h00;
    end else begin
      state       <= state_nx;
      dl_active_q <= dl_active;
      hit_ack_q   <= hit_take;
      if (hit_take) hit_data_q <= cache_data;

      if (grant_dl) begin
        owner   <= OWN_DL;
        op_addr <= dl_addr_q;
        op_data <= dl_data_q;
        op_we   <= 1'b1;
      end else if (grant_rom) begin
        owner   <= OWN_ROM;
        op_addr <= rom_sdram;
        op_we   <= 1'b0;
      end else if (grant_sav) begin
        owner   <= OWN_SAV;
        op_addr <= sav_sdram;
        op_data <= sav_din;
        op_we   <= sav_we;
      end

      if (state == ISSUE)     wait_cnt <= 8'h00;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'h01;
      if (timed_out) err_q <= 1'b1;

      // A new strobe landing on the completion cycle stays pending and is not an overflow.
      if (dl_wr) begin
        dl_pend   <= 1'b1;
        dl_addr_q <= dl_addr;
        dl_data_q <= dl_data;
        if (dl_pend && !dl_done) dl_ovf_q <= 1'b1;
      end else if (dl_done) begin
        dl_pend <= 1'b0;
      end
    end
  end

  assign mem_addr    = op_addr;
  assign mem_din     = op_data;
  assign mem_we      = (state == ISSUE) && op_we;
  assign mem_rd      = (state == ISSUE) && !op_we;
  assign dl_wait     = dl_pend;
  assign dl_ovf      = dl_ovf_q;
  assign err_timeout = err_q;
  assign rom_ack     = rom_done || hit_ack_q;
  assign rom_data    = rom_done ? rd_val : (hit_ack_q ? hit_data_q : 8'h00);

`ifdef SMS_SAVE_PORT_EN
  assign sav_ack  = sav_done;
  assign sav_dout = sav_done ? rd_val : 8'h00;
`else
  assign sav_ack  = 1'b0;
  assign sav_dout = 8'h00;
`endif

endmodule
